pilot_inserter: RTL and testbench
=================================

# pilot_inserter

Stream stage directly downstream of the frame counter in the pilot-insertion path. On each `start_frame` pulse it emits a burst of `pilot_length` pilot symbols. It then passes payload symbols from the input stream to the output stream, and marks the beat that closes the frame (flagged by `end_frame`) with `m_axis_tlast`. It returns per-beat `ready` and `pilot_flag` pulses so the frame counter can count every symbol it places on the output.

## Interface
- `DATA_WIDTH`, 32 — symbol width; I in `[31:16]`, Q in `[15:0]`, both signed two's complement.
- `PLEN_W`, 8 — width of `pilot_length`.

Ports:
- `clk` in 1 — single clock; all logic rising-edge.
- `rst` in 1 — reset, asynchronous, active-low.
- `start_frame` in 1 — one-cycle pulse; request a pilot burst.
- `end_frame` in 1 — one-cycle pulse; the next payload beat issued closes the frame.
- `pilot_length` in `PLEN_W` — pilots per burst; sampled on entry to PILOT.
- `pilot_value` in 16 — pilot I amplitude (signed); Q is always 0.
- `s_axis_tdata` in `DATA_WIDTH` — payload symbol.
- `s_axis_tvalid` in 1 — payload valid.
- `s_axis_tready` out 1 — payload accepted when high with `s_axis_tvalid`.
- `m_axis_tdata` out `DATA_WIDTH` — output symbol.
- `m_axis_tvalid` out 1 — output valid.
- `m_axis_tready` in 1 — downstream ready.
- `m_axis_tlast` out 1 — last beat of frame.
- `ready` out 1 — one-cycle pulse per payload beat loaded into the output register.
- `pilot_flag` out 1 — one-cycle pulse per pilot beat loaded into the output register.

## Operation
- FSM states: IDLE, PILOT, DATA. Reset state is IDLE.
- Output register: a single register holds data, valid and last. It loads when `!m_axis_tvalid || m_axis_tready` ("slot free").
- `start_pend` is set by `start_frame` and cleared when the FSM enters PILOT or DATA from a start.
- `end_pend` is set by `end_frame` and cleared when a payload beat is loaded with `m_axis_tlast=1`.
- IDLE:
  - If `start_pend` and `pilot_length != 0`, go to PILOT and load the pilot counter.
  - If `start_pend` and `pilot_length == 0`, go straight to DATA.
  - Payload is not accepted in IDLE (`s_axis_tready=0`).
- PILOT:
  - Each free slot loads one pilot beat, pulses `pilot_flag` and decrements the counter.
  - After the last pilot beat, go to DATA.
  - `s_axis_tready=0`.
  - Pilot beats never carry `m_axis_tlast`.
- DATA:
  - `s_axis_tready` = slot free.
  - Each accepted beat is loaded with `m_axis_tlast = end_pend`, and `ready` pulses.
  - After the beat with `tlast`: go to PILOT (or DATA if `pilot_length==0`) when `start_pend`, else go to IDLE.
- Simultaneous events:
  - `start_frame` during PILOT/DATA stays pending until the current frame closes. It never truncates a burst or frame.
  - `end_frame` in the same cycle as a payload acceptance applies to the following beat, not the current one.
  - `end_frame` arriving during IDLE or PILOT is held and applied to the first payload beat.
- Pilot symbol: I = `pilot_value`, Q = 0, optionally sign-flipped (see Configuration). Negating -32768 saturates to +32767.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata`, `s_axis_tready`, `ready`, `pilot_flag` are all 0; both pending flags 0; state IDLE.
- Latency, payload: input beat accepted at edge N appears on `m_axis_tdata` after edge N, i.e. a 1-cycle register.
- Latency, start to pilot: `start_frame` high at edge N; the FSM leaves IDLE at N+1; the first pilot beat is valid after N+2.
- Throughput: with `m_axis_tready` held high, one beat per cycle, with no bubble between pilot and payload beats.
- Backpressure: while `m_axis_tvalid && !m_axis_tready`, data, last and valid are held stable, and no `ready`/`pilot_flag` pulses occur.
- Reset mid-frame: everything returns immediately to reset values; the in-flight beat is dropped.

## Configuration
- `PILOT_PRBS_EN` defined:
  - Pilot sign follows PRBS7 (x^7+x^6+1), seed `7'h7F`, reloaded at each PILOT entry and advanced once per pilot beat.
  - Bit 1 negates I.
- `PILOT_PRBS_EN` undefined:
  - Every pilot is the constant `pilot_value`.
  - No PRBS logic is synthesised.

## Structure
- Package `pilot_pkg` holds:
  - the state enum (IDLE/PILOT/DATA),
  - the PRBS7 tap and seed constants,
  - the I/Q field widths,
  - the saturating-negate function.
- Sub-module `prbs7_gen` (inputs: `clk`, `rst`, `load`, `advance`; output: `bit`), instantiated only under `PILOT_PRBS_EN`.

## Test plan
- Basic frame: `pilot_length=4`, `pilot_value=16'h4000`, `m_axis_tready=1`, `start_frame` then 10 payload beats, `end_frame` before beat 10 → 4 pilots with I=`16'h4000`, Q=0; 10 payload beats in order; `tlast` only on beat 10; 4 `pilot_flag` and 10 `ready` pulses.
- Backpressure: same stimulus, `m_axis_tready` toggling 1-0-1 → output stable while stalled; identical beat sequence; pulse counts unchanged.
- Zero pilots: `pilot_length=0` → first output beat is payload, 2 cycles after `start_frame`.
- Back-to-back frames: `start_frame` during DATA → the second pilot burst starts on the beat immediately after `tlast`, with no idle cycle.
- PRBS (`PILOT_PRBS_EN`): `pilot_length=8`, `pilot_value=16'h8000` → pilot I values follow the PRBS7 sign sequence from seed `7'h7F`, with negated values = `16'h7FFF`.
- Reset mid-PILOT: `rst` low after 2 pilots → outputs 0 at once; after release the FSM sits in IDLE until a new `start_frame`.

Source files
------------

// File: rtl/pilot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pilot_pkg : shared types and constants for the pilot insertion path  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package pilot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PILOT = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam int          c_iq_w       = 16;
  localparam logic [6:0]  c_prbs7_seed = 7'h7F;
  // x^7 + x^6 + 1 : feedback from the two most significant stages
  localparam logic [6:0]  c_prbs7_taps = 7'b110_0000;
  localparam logic [15:0] c_iq_min     = 16'h8000;
  localparam logic [15:0] c_iq_max     = 16'h7FFF;

  function automatic logic [c_iq_w-1:0] sat_neg(input logic [c_iq_w-1:0] v);
    if (v == c_iq_min) begin
      return c_iq_max;
    end
    return (~v) + c_iq_w'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pilot_inserter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pilot_inserter_if : payload input and symbol output stream bundle    |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
interface pilot_inserter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface
`default_nettype wire

// File: rtl/prbs7_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prbs7_gen : PRBS7 sign source, reloadable seed, steps on advance     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module prbs7_gen
  import pilot_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic prbs_bit
);

  logic [6:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= c_prbs7_seed;
    end else if (load) begin
      r_lfsr <= c_prbs7_seed;
    end else if (advance) begin
      r_lfsr <= {r_lfsr[5:0], ^(r_lfsr & c_prbs7_taps)};
    end
  end

  assign prbs_bit = r_lfsr[6];

endmodule
`default_nettype wire

// File: rtl/pilot_inserter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pilot_inserter : pilot burst on start_frame, then payload pass-thru  |
// |   with tlast on the frame-closing beat. PILOT_PRBS_EN: PRBS7 signs.  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module pilot_inserter
  import pilot_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PLEN_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_frame,
  input  logic              end_frame,
  input  logic [PLEN_W-1:0] pilot_length,
  input  logic [c_iq_w-1:0] pilot_value,
  pilot_inserter_if.slave   axis,
  output logic              ready,
  output logic              pilot_flag
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [PLEN_W-1:0]       r_cnt;
  logic                    r_start_pend;
  logic                    r_end_pend;
  logic [DATA_WIDTH-1:0]   r_m_data;
  logic                    r_m_valid;
  logic                    r_m_last;
  logic                    r_ready;
  logic                    r_pilot_flag;

  logic                    w_slot_free;
  logic                    w_s_ready;
  logic                    w_accept;
  logic                    w_pilot_load;
  logic                    w_last_beat;
  logic                    w_cnt_load;
  logic                    w_start_take;
  logic [c_iq_w-1:0]       w_pilot_i;
  logic [DATA_WIDTH-1:0]   w_pilot_word;

  assign w_slot_free  = !r_m_valid || axis.m_axis_tready;
  assign w_s_ready    = (r_state == DATA) && w_slot_free;
  assign w_accept     = w_s_ready && axis.s_axis_tvalid;
  assign w_pilot_load = (r_state == PILOT) && w_slot_free;
  assign w_last_beat  = w_accept && r_end_pend;

`ifdef PILOT_PRBS_EN
  logic w_prbs_bit;

  prbs7_gen u_prbs7_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .advance  (w_pilot_load),
    .prbs_bit (w_prbs_bit)
  );

  assign w_pilot_i = w_prbs_bit ? sat_neg(pilot_value) : pilot_value;
`else
  assign w_pilot_i = pilot_value;
`endif

  assign w_pilot_word = {w_pilot_i, {(DATA_WIDTH-c_iq_w){1'b0}}};

  // A pending start is consumed from IDLE or straight after a closing beat.
  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_start_take = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_start_pend) begin
          w_start_take = 1'b1;
          if (pilot_length != '0) begin
            w_state_next = PILOT;
            w_cnt_load   = 1'b1;
          end else begin
            w_state_next = DATA;
          end
        end
      end
      PILOT: begin
        if (w_pilot_load && (r_cnt == PLEN_W'(1))) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_last_beat) begin
          if (r_start_pend) begin
            w_start_take = 1'b1;
            if (pilot_length != '0) begin
              w_state_next = PILOT;
              w_cnt_load   = 1'b1;
            end else begin
              w_state_next = DATA;
            end
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_start_pend <= 1'b0;
      r_end_pend   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_load) begin
        r_cnt <= pilot_length;
      end else if (w_pilot_load) begin
        r_cnt <= r_cnt - PLEN_W'(1);
      end
      // New requests win over same-cycle consumption so none is lost.
      if (start_frame) begin
        r_start_pend <= 1'b1;
      end else if (w_start_take) begin
        r_start_pend <= 1'b0;
      end
      if (end_frame) begin
        r_end_pend <= 1'b1;
      end else if (w_last_beat) begin
        r_end_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_ready      <= 1'b0;
      r_pilot_flag <= 1'b0;
    end else begin
      r_ready      <= w_accept;
      r_pilot_flag <= w_pilot_load;
      if (w_pilot_load) begin
        r_m_data  <= w_pilot_word;
        r_m_valid <= 1'b1;
        r_m_last  <= 1'b0;
      end else if (w_accept) begin
        r_m_data  <= axis.s_axis_tdata;
        r_m_valid <= 1'b1;
        r_m_last  <= r_end_pend;
      end else if (w_slot_free) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  assign axis.s_axis_tready = w_s_ready;
  assign axis.m_axis_tdata  = r_m_data;
  assign axis.m_axis_tvalid = r_m_valid;
  assign axis.m_axis_tlast  = r_m_last;
  assign ready              = r_ready;
  assign pilot_flag         = r_pilot_flag;

endmodule
`default_nettype wire

// File: tb/tb_pilot_inserter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pilot_inserter : directed vector table plus corner-case sequences |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_pilot_inserter;

  typedef struct {
    int          plen;
    logic [15:0] pval;
    int          npay;
    bit          bp;
    int          exp_beats;
    int          exp_pf;
    int          exp_rd;
  } vec_t;

`ifdef PILOT_PRBS_EN
  localparam int NV = 6;
`else
  localparam int NV = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_frame;
  logic        end_frame;
  logic [7:0]  pilot_length;
  logic [15:0] pilot_value;
  logic        ready;
  logic        pilot_flag;

  always #5 clk = ~clk;

  pilot_inserter_if #(.DATA_WIDTH(32)) axis ();

  pilot_inserter #(.DATA_WIDTH(32), .PLEN_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_frame  (start_frame),
    .end_frame    (end_frame),
    .pilot_length (pilot_length),
    .pilot_value  (pilot_value),
    .axis         (axis),
    .ready        (ready),
    .pilot_flag   (pilot_flag)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] bd [0:1023];
  logic        bl [0:1023];
  int          bc [0:1023];
  int          nb = 0;
  int          pf_total = 0;
  int          rd_total = 0;
  int          cyc_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_bus = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pilot(input int k, input logic [15:0] pv);
`ifdef PILOT_PRBS_EN
    logic [6:0] s;
`endif
    logic [15:0] i_val;
    i_val = pv;
`ifdef PILOT_PRBS_EN
    s = 7'h7F;
    for (int j = 0; j < k; j++) s = {s[5:0], s[6] ^ s[5]};
    if (s[6]) i_val = (pv == 16'h8000) ? 16'h7FFF : (~pv + 16'd1);
`endif
    return {i_val, 16'h0000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // Mid-cycle observation: record handed-off beats, count pulses, check stalls.
  task automatic sample();
    #3;
    if (prev_stall) begin
      check("stall_hold", {30'd0, axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tdata},
            {30'd0, prev_bus});
      check("stall_pulse", {62'd0, ready, pilot_flag}, 64'd0);
    end
    if (axis.m_axis_tvalid && axis.m_axis_tready && nb < 1024) begin
      bd[nb] = axis.m_axis_tdata;
      bl[nb] = axis.m_axis_tlast;
      bc[nb] = cyc_cnt;
      nb++;
    end
    pf_total += int'(pilot_flag);
    rd_total += int'(ready);
    prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
    prev_bus   = {axis.m_axis_tvalid, axis.m_axis_tlast, axis.m_axis_tdata};
  endtask

  task automatic drain(input int n);
    axis.m_axis_tready = 1'b1;
    repeat (n) begin
      sample();
      step();
    end
  endtask

  // end_frame rides on the acceptance of the second-last beat (applies to the next one).
  task automatic send_payload(input int npay, input bit bp, input int start_at,
                              input logic [31:0] base);
    int   idx;
    int   cyc;
    logic acc;
    idx = 0;
    cyc = 0;
    while (idx < npay && cyc < 400) begin
      axis.m_axis_tready = bp ? ((cyc % 3) != 1) : 1'b1;
      axis.s_axis_tvalid = 1'b1;
      axis.s_axis_tdata  = base + 32'(idx);
      sample();
      acc         = axis.s_axis_tready;
      end_frame   = acc && (idx == npay - 2);
      start_frame = acc && (idx == start_at);
      step();
      end_frame   = 1'b0;
      start_frame = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    axis.s_axis_tvalid = 1'b0;
    check("payload_sent", 64'(idx), 64'(npay));
  endtask

  task automatic check_frame(input int b, input int plen, input logic [15:0] pv,
                             input int npay, input logic [31:0] base);
    for (int k = 0; k < plen; k++) begin
      check("pilot_data", 64'(bd[b+k]), 64'(exp_pilot(k, pv)));
      check("pilot_last", 64'(bl[b+k]), 64'd0);
    end
    for (int j = 0; j < npay; j++) begin
      check("pay_data", 64'(bd[b+plen+j]), 64'(base + 32'(j)));
      check("pay_last", 64'(bl[b+plen+j]), 64'(j == npay - 1));
    end
  endtask

  initial begin
    vec_t vecs [NV];
    int   b0;
    int   pf0;
    int   rd0;
    int   cyc;

    vecs[0] = '{4, 16'h4000, 10, 1'b0, 14, 4, 10};
    vecs[1] = '{4, 16'h4000, 10, 1'b1, 14, 4, 10};
    vecs[2] = '{1, 16'h8000,  3, 1'b0,  4, 1,  3};
    vecs[3] = '{0, 16'h1234,  5, 1'b1,  5, 0,  5};
    vecs[4] = '{7, 16'hFFFF,  2, 1'b1,  9, 7,  2};
`ifdef PILOT_PRBS_EN
    vecs[5] = '{8, 16'h8000,  4, 1'b0, 12, 8,  4};
`endif

    rst                = 1'b0;
    start_frame        = 1'b0;
    end_frame          = 1'b0;
    pilot_length       = 8'd0;
    pilot_value        = 16'h0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata  = 32'h0;
    axis.m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(axis.m_axis_tvalid), 64'd0);
    check("rst_m_last",  64'(axis.m_axis_tlast),  64'd0);
    check("rst_m_data",  64'(axis.m_axis_tdata),  64'd0);
    check("rst_s_ready", 64'(axis.s_axis_tready), 64'd0);
    check("rst_ready",   64'(ready),              64'd0);
    check("rst_pflag",   64'(pilot_flag),         64'd0);
    rst = 1'b1;
    axis.m_axis_tready = 1'b1;
    step();
    check("idle_m_valid", 64'(axis.m_axis_tvalid), 64'd0);
    check("idle_s_ready", 64'(axis.s_axis_tready), 64'd0);

    for (int c = 0; c < NV; c++) begin
      b0  = nb;
      pf0 = pf_total;
      rd0 = rd_total;
      pilot_length = 8'(vecs[c].plen);
      pilot_value  = vecs[c].pval;
      prev_stall   = 1'b0;
      axis.m_axis_tready = 1'b1;
      start_frame = 1'b1;
      sample();
      step();
      start_frame = 1'b0;
      send_payload(vecs[c].npay, vecs[c].bp, -1, 32'hA000_0000 + (32'(c) << 16));
      drain(6);
      check("beats",       64'(nb - b0),       64'(vecs[c].exp_beats));
      check("pflag_count", 64'(pf_total - pf0), 64'(vecs[c].exp_pf));
      check("ready_count", 64'(rd_total - rd0), 64'(vecs[c].exp_rd));
      check_frame(b0, vecs[c].plen, vecs[c].pval, vecs[c].npay, 32'hA000_0000 + (32'(c) << 16));
    end

    // Zero pilots, end_frame held from IDLE onto the first payload beat.
    pilot_length       = 8'd0;
    axis.m_axis_tready = 1'b1;
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tdata  = 32'hDEAD_BEEF;
    start_frame = 1'b1;
    end_frame   = 1'b1;
    step();
    start_frame = 1'b0;
    end_frame   = 1'b0;
    check("zp_n0_valid",  64'(axis.m_axis_tvalid), 64'd0);
    check("zp_n0_sready", 64'(axis.s_axis_tready), 64'd0);
    step();
    check("zp_n1_valid",  64'(axis.m_axis_tvalid), 64'd0);
    check("zp_n1_sready", 64'(axis.s_axis_tready), 64'd1);
    step();
    axis.s_axis_tvalid = 1'b0;
    check("zp_n2_valid", 64'(axis.m_axis_tvalid), 64'd1);
    check("zp_n2_data",  64'(axis.m_axis_tdata),  64'hDEAD_BEEF);
    check("zp_n2_last",  64'(axis.m_axis_tlast),  64'd1);
    check("zp_n2_ready", 64'({ready, pilot_flag}), 64'd2);
    step();
    check("zp_n3_valid",  64'(axis.m_axis_tvalid), 64'd0);
    check("zp_n3_sready", 64'(axis.s_axis_tready), 64'd0);

    // Back-to-back: second start arrives during DATA of the first frame.
    pilot_length = 8'd2;
    pilot_value  = 16'h1000;
    prev_stall   = 1'b0;
    b0  = nb;
    pf0 = pf_total;
    rd0 = rd_total;
    axis.m_axis_tready = 1'b1;
    start_frame = 1'b1;
    sample();
    step();
    start_frame = 1'b0;
    send_payload(3, 1'b0, 0, 32'hB000_0000);
    send_payload(2, 1'b0, -1, 32'hC000_0000);
    drain(6);
    check("b2b_beats", 64'(nb - b0),       64'd9);
    check("b2b_pflag", 64'(pf_total - pf0), 64'd4);
    check("b2b_ready", 64'(rd_total - rd0), 64'd5);
    check_frame(b0,     2, 16'h1000, 3, 32'hB000_0000);
    check_frame(b0 + 5, 2, 16'h1000, 2, 32'hC000_0000);
    check("b2b_pilot_to_pay_gap", 64'(bc[b0+2] - bc[b0+1]), 64'd1);
    check("b2b_last_to_pilot_gap", 64'(bc[b0+5] - bc[b0+4]), 64'd1);

    // Reset asserted after two pilots of a six-pilot burst.
    pilot_length = 8'd6;
    pilot_value  = 16'h2222;
    axis.m_axis_tready = 1'b1;
    axis.s_axis_tvalid = 1'b0;
    prev_stall = 1'b0;
    b0 = nb;
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    cyc = 0;
    sample();
    while (nb - b0 < 2 && cyc < 20) begin
      step();
      sample();
      cyc++;
    end
    check("rst_two_pilots", 64'(nb - b0), 64'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_valid",  64'(axis.m_axis_tvalid), 64'd0);
    check("mid_rst_last",   64'(axis.m_axis_tlast),  64'd0);
    check("mid_rst_data",   64'(axis.m_axis_tdata),  64'd0);
    check("mid_rst_sready", 64'(axis.s_axis_tready), 64'd0);
    check("mid_rst_pulses", 64'({ready, pilot_flag}), 64'd0);
    step();
    step();
    rst = 1'b1;
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tdata  = 32'h5555_AAAA;
    repeat (4) begin
      step();
      check("post_rst_idle_valid",  64'(axis.m_axis_tvalid), 64'd0);
      check("post_rst_idle_sready", 64'(axis.s_axis_tready), 64'd0);
    end
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    check("sp_n0_valid", 64'(axis.m_axis_tvalid), 64'd0);
    step();
    check("sp_n1_valid", 64'(axis.m_axis_tvalid), 64'd0);
    step();
    check("sp_n2_valid", 64'(axis.m_axis_tvalid), 64'd1);
    check("sp_n2_data",  64'(axis.m_axis_tdata),  64'(exp_pilot(0, 16'h2222)));
    check("sp_n2_pflag", 64'(pilot_flag),         64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
